if_fetch_unit: RTL

//  Parametrised instruction-fetch front end; successor to the single-register PC stage.
//  - Issues PC-addressed requests to instruction memory over a valid/ready port.
//  - Tolerates multi-cycle, in-order responses and buffers fetched instructions in a FIFO.
//  - Hands {pc, inst, misalign flag} to decode over a valid/ready port.
//  - Handles exception and branch redirects, discarding stale in-flight responses.

---
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues PC-addressed memory requests, tolerates
// multi-cycle in-order responses, queues results for decode, and handles redirects.
module if_fetch_unit #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     ILEN     = 32,
   parameter int unsigned     FQ_DEPTH = 4,
   parameter logic [XLEN-1:0] PC_START = 64'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            excp_jmp_ena,
   input  logic [XLEN-1:0] excp_pc,
   input  logic            bj_ena,
   input  logic [XLEN-1:0] new_pc,
   output logic            imem_req_vld,
   input  logic            imem_req_rdy,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_vld,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            if_vld,
   input  logic            if_rdy,
   output logic [XLEN-1:0] if_pc,
   output logic [ILEN-1:0] if_inst,
   output logic            if_misal
);

   localparam int unsigned    AW      = $clog2(FQ_DEPTH);
   localparam int unsigned    CW      = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(FQ_DEPTH);

   logic [XLEN-1:0] pc;
   logic            active;
   logic            halt;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;

   logic [XLEN-1:0] fq_pc    [FQ_DEPTH];
   logic [ILEN-1:0] fq_inst  [FQ_DEPTH];
   logic            fq_misal [FQ_DEPTH];
   logic [AW-1:0]   fq_rd;
   logic [AW-1:0]   fq_wr;
   logic [CW-1:0]   fq_cnt;

   logic [XLEN-1:0] tag_q [FQ_DEPTH];
   logic [AW-1:0]   tag_rd;
   logic [AW-1:0]   tag_wr;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            pc_misal;
   logic            credit;
   logic            req_fire;
   logic            rsp_take;
   logic            rsp_push;
   logic            misal_push;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] push_pc;
   logic [ILEN-1:0] push_inst;

   always_comb begin
      redirect   = excp_jmp_ena | bj_ena;
      target     = excp_jmp_ena ? excp_pc : new_pc;
      pc_misal   = (pc[1:0] != 2'b00);
      // Credit covers both outstanding responses and queued entries, so a
      // response always finds a free FIFO slot.
      credit     = ({1'b0, inflight} + {1'b0, fq_cnt}) < {1'b0, DEPTH_C};
      imem_req_vld  = active & ~redirect & ~halt & ~pc_misal & credit;
      imem_req_addr = pc;
      req_fire   = imem_req_vld & imem_req_rdy;
      rsp_take   = imem_rsp_vld & (inflight != '0);
      rsp_push   = rsp_take & ~redirect & (drop == '0);
      misal_push = active & ~redirect & ~halt & pc_misal &
                   (inflight == '0) & (fq_cnt != DEPTH_C);
      push       = rsp_push | misal_push;
      push_pc    = rsp_push ? tag_q[tag_rd] : pc;
      push_inst  = rsp_push ? imem_rsp_data : '0;
      if_vld     = (fq_cnt != '0);
      pop        = if_vld & if_rdy;
      if_pc      = if_vld ? fq_pc[fq_rd]    : '0;
      if_inst    = if_vld ? fq_inst[fq_rd]  : '0;
      if_misal   = if_vld ? fq_misal[fq_rd] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= PC_START;
         active   <= 1'b0;
         halt     <= 1'b0;
         inflight <= '0;
         drop     <= '0;
         fq_rd    <= '0;
         fq_wr    <= '0;
         fq_cnt   <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
      end else begin
         active   <= 1'b1;
         inflight <= inflight + CW'(req_fire) - CW'(rsp_take);
         if (req_fire) tag_wr <= tag_wr + AW'(1);
         if (rsp_take) tag_rd <= tag_rd + AW'(1);
         if (redirect) begin
            // Everything still outstanding belongs to the old stream.
            pc     <= target;
            halt   <= 1'b0;
            drop   <= inflight - CW'(rsp_take);
            fq_rd  <= '0;
            fq_wr  <= '0;
            fq_cnt <= '0;
         end else begin
            if (req_fire)                  pc   <= pc + XLEN'(4);
            if (misal_push)                halt <= 1'b1;
            if (rsp_take && drop != '0)    drop <= drop - CW'(1);
            if (push)                      fq_wr <= fq_wr + AW'(1);
            if (pop)                       fq_rd <= fq_rd + AW'(1);
            fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fq_pc[fq_wr]    <= push_pc;
         fq_inst[fq_wr]  <= push_inst;
         fq_misal[fq_wr] <= misal_push;
      end
      if (req_fire) tag_q[tag_wr] <= pc;
   end

endmodule
